// File: rtl/sp_unit_if.sv
// Control and status bundle between the control unit and the stack pointer unit.
// Signal suffixes are taken from the unit's point of view.
interface sp_unit_if #(
  parameter int WIDTH = 8,
  parameter int CW    = 9
);
  logic             sp_ld_i;
  logic             sp_incr_i;
  logic             sp_decr_i;
  logic             sp_save_i;
  logic             sp_restore_i;
  logic             clr_fault_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] data_out_o;
  logic [CW-1:0]    count_o;
  logic             empty_o;
  logic             full_o;
  logic             ovf_o;
  logic             unf_o;
  logic             fault_o;

  modport master (
    output sp_ld_i, sp_incr_i, sp_decr_i, sp_save_i, sp_restore_i, clr_fault_i, a_i,
    input  data_out_o, count_o, empty_o, full_o, ovf_o, unf_o, fault_o
  );

  modport slave (
    input  sp_ld_i, sp_incr_i, sp_decr_i, sp_save_i, sp_restore_i, clr_fault_i, a_i,
    output data_out_o, count_o, empty_o, full_o, ovf_o, unf_o, fault_o
  );
endinterface

// File: rtl/sp_unit.sv
// Stack pointer with bounded occupancy, sticky over/underflow flags,
// optional halt-on-fault and a one-deep shadow for interrupt context.
//   state   | meaning
//   S_RUN   | normal operation
//   S_FAULT | halted after a violation (FAULT_HALT=1); push/pop ignored
module sp_unit #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 256,
  parameter int RESET_VAL  = 0,
  parameter int FAULT_HALT = 0,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input logic       clk_i,
  input logic       rst_i,
  sp_unit_if.slave  bus
);

  typedef enum logic {S_RUN, S_FAULT} state_t;

  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [WIDTH-1:0] RST_SP  = WIDTH'(RESET_VAL);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sp_q, sp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shd_sp_q, shd_sp_d;
  logic [CW-1:0]    shd_cnt_q, shd_cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             viol_ovf, viol_unf;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_RUN;
      sp_q      <= RST_SP;
      cnt_q     <= '0;
      shd_sp_q  <= RST_SP;
      shd_cnt_q <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sp_q      <= sp_d;
      cnt_q     <= cnt_d;
      shd_sp_q  <= shd_sp_d;
      shd_cnt_q <= shd_cnt_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    cnt_d     = cnt_q;
    shd_sp_d  = shd_sp_q;
    shd_cnt_d = shd_cnt_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    viol_ovf  = 1'b0;
    viol_unf  = 1'b0;

    // Only the highest-priority pointer op is evaluated, including for violations.
    if (bus.sp_restore_i) begin
      sp_d  = shd_sp_q;
      cnt_d = shd_cnt_q;
    end else if (bus.sp_ld_i) begin
      sp_d  = bus.a_i;
      cnt_d = '0;
    end else if (bus.sp_incr_i) begin
      if (state_q == S_RUN) begin
        if (cnt_q == '0) begin
          viol_unf = 1'b1;
        end else begin
          sp_d  = sp_q + WIDTH'(1);
          cnt_d = cnt_q - CW'(1);
        end
      end
    end else if (bus.sp_decr_i) begin
      if (state_q == S_RUN) begin
        if (cnt_q == DEPTH_C) begin
          viol_ovf = 1'b1;
        end else begin
          sp_d  = sp_q - WIDTH'(1);
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    // Shadow takes the pre-edge value, so SAVE+RESTORE swaps live and shadow.
    if (bus.sp_save_i) begin
      shd_sp_d  = sp_q;
      shd_cnt_d = cnt_q;
    end

    if (bus.clr_fault_i) begin
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      state_d = S_RUN;
    end
    if (bus.sp_restore_i || bus.sp_ld_i) begin
      state_d = S_RUN;
    end
    if (viol_ovf) begin
      ovf_d = 1'b1;
    end
    if (viol_unf) begin
      unf_d = 1'b1;
    end
    if ((viol_ovf || viol_unf) && (FAULT_HALT != 0)) begin
      state_d = S_FAULT;
    end
  end

  assign bus.data_out_o = sp_q;
  assign bus.count_o    = cnt_q;
  assign bus.empty_o    = (cnt_q == '0);
  assign bus.full_o     = (cnt_q == DEPTH_C);
  assign bus.ovf_o      = ovf_q;
  assign bus.unf_o      = unf_q;
  assign bus.fault_o    = (state_q == S_FAULT);

endmodule

// File: tb/tb_sp_unit.sv
// Scoreboarded bench driving identical stimulus into a drop-mode and a
// halt-mode instance (WIDTH=8, DEPTH=4, RESET_VAL=0).
module tb_sp_unit;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  localparam logic [5:0] LD  = 6'b000001;
  localparam logic [5:0] INC = 6'b000010;
  localparam logic [5:0] DEC = 6'b000100;
  localparam logic [5:0] SAV = 6'b001000;
  localparam logic [5:0] RES = 6'b010000;
  localparam logic [5:0] CLR = 6'b100000;

  typedef struct {
    logic [W-1:0]  sp;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic          unf;
    logic          flt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  exp_t          sbq[$];
  logic [W-1:0]  m_sp[2], m_shs[2];
  logic [CW-1:0] m_cnt[2], m_shc[2];
  logic          m_ovf[2], m_unf[2], m_flt[2];

  always #5 clk = ~clk;

  sp_unit_if #(.WIDTH(W), .CW(CW)) bus0 ();
  sp_unit_if #(.WIDTH(W), .CW(CW)) bus1 ();

  sp_unit #(.WIDTH(W), .DEPTH(D), .RESET_VAL(0), .FAULT_HALT(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .bus(bus0)
  );
  sp_unit #(.WIDTH(W), .DEPTH(D), .RESET_VAL(0), .FAULT_HALT(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cmp(input int k, input exp_t e, input logic [W-1:0] sp,
                     input logic [CW-1:0] cnt, input logic empty, input logic full,
                     input logic ovf, input logic unf, input logic flt);
    string p;
    p = $sformatf("dut%0d_", k);
    chk({p, "data_out"}, 32'(sp), 32'(e.sp));
    chk({p, "count"}, 32'(cnt), 32'(e.cnt));
    chk({p, "empty"}, 32'(empty), 32'(e.cnt == 0));
    chk({p, "full"}, 32'(full), 32'(e.cnt == CW'(D)));
    chk({p, "ovf"}, 32'(ovf), 32'(e.ovf));
    chk({p, "unf"}, 32'(unf), 32'(e.unf));
    chk({p, "fault"}, 32'(flt), 32'(e.flt));
  endtask

  task automatic check_both(input exp_t e0, input exp_t e1);
    cmp(0, e0, bus0.data_out_o, bus0.count_o, bus0.empty_o, bus0.full_o,
        bus0.ovf_o, bus0.unf_o, bus0.fault_o);
    cmp(1, e1, bus1.data_out_o, bus1.count_o, bus1.empty_o, bus1.full_o,
        bus1.ovf_o, bus1.unf_o, bus1.fault_o);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_sp[k] = '0; m_cnt[k] = '0; m_shs[k] = '0; m_shc[k] = '0;
      m_ovf[k] = 1'b0; m_unf[k] = 1'b0; m_flt[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input logic [5:0] o, input logic [W-1:0] a);
    logic [W-1:0]  osp;
    logic [CW-1:0] ocnt;
    bit            vu, vo;
    osp  = m_sp[k];
    ocnt = m_cnt[k];
    vu   = 1'b0;
    vo   = 1'b0;
    if (o[4]) begin
      m_sp[k] = m_shs[k]; m_cnt[k] = m_shc[k];
    end else if (o[0]) begin
      m_sp[k] = a; m_cnt[k] = '0;
    end else if (o[1]) begin
      if (!m_flt[k]) begin
        if (ocnt == 0) vu = 1'b1;
        else begin m_sp[k] = osp + 8'd1; m_cnt[k] = ocnt - 1'b1; end
      end
    end else if (o[2]) begin
      if (!m_flt[k]) begin
        if (ocnt == CW'(D)) vo = 1'b1;
        else begin m_sp[k] = osp - 8'd1; m_cnt[k] = ocnt + 1'b1; end
      end
    end
    if (o[3]) begin m_shs[k] = osp; m_shc[k] = ocnt; end
    if (o[5]) begin m_ovf[k] = 1'b0; m_unf[k] = 1'b0; m_flt[k] = 1'b0; end
    if (o[4] || o[0]) m_flt[k] = 1'b0;
    if (vu) m_unf[k] = 1'b1;
    if (vo) m_ovf[k] = 1'b1;
    if ((vu || vo) && k == 1) m_flt[k] = 1'b1;
  endtask

  task automatic drive(input logic [5:0] o, input logic [W-1:0] a);
    {bus0.clr_fault_i, bus0.sp_restore_i, bus0.sp_save_i,
     bus0.sp_decr_i, bus0.sp_incr_i, bus0.sp_ld_i} = o;
    {bus1.clr_fault_i, bus1.sp_restore_i, bus1.sp_save_i,
     bus1.sp_decr_i, bus1.sp_incr_i, bus1.sp_ld_i} = o;
    bus0.a_i = a;
    bus1.a_i = a;
  endtask

  task automatic op(input logic [5:0] o, input logic [W-1:0] a = '0);
    exp_t e0, e1;
    @(negedge clk);
    drive(o, a);
    for (int k = 0; k < 2; k++) begin
      model_step(k, o, a);
      sbq.push_back('{m_sp[k], m_cnt[k], m_ovf[k], m_unf[k], m_flt[k]});
    end
    @(posedge clk);
    #1;
    if (sbq.size() < 2) begin
      chk("sb_underrun", 32'(sbq.size()), 32'd2);
    end else begin
      e0 = sbq.pop_front();
      e1 = sbq.pop_front();
      check_both(e0, e1);
    end
    drive('0, '0);
  endtask

  initial begin
    exp_t z;
    z = '{8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
    rst = 1'b1;
    drive('0, '0);
    model_reset();
    #3;
    check_both(z, z);
    @(negedge clk);
    rst = 1'b0;

    // Fill to DEPTH, then overflow; halt instance freezes
    repeat (5) op(DEC);
    op(INC);
    op(CLR);
    op(INC);

    // Underflow from an empty stack, then clear
    op(LD, 8'h00);
    op(INC);
    op(CLR);

    // Save, prioritised load, restore
    op(LD, 8'h80);
    op(DEC);
    op(DEC);
    op(SAV);
    op(LD | INC | DEC, 8'h40);
    op(RES);

    // LD beats INC/DEC; INC beats DEC and underflows
    op(LD | INC | DEC, 8'h10);
    op(INC | DEC);
    op(CLR | INC);
    op(CLR);

    // Wrap both directions, then SAVE+RESTORE swap
    op(LD, 8'h01);
    op(DEC);
    op(DEC);
    op(INC);
    op(SAV | RES);
    op(RES);

    // Async reset between edges with COUNT=3 and OVF=1
    op(LD, 8'h00);
    repeat (5) op(DEC);
    op(INC);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_both(z, z);
    rst = 1'b0;
    op(RES);

    for (int i = 0; i < 60; i++) begin
      op(6'($urandom_range(0, 63)) & 6'($urandom_range(0, 63)), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/sp_unit.md
# sp_unit

Parametrised stack pointer unit for the RAT CPU and derived cores. It holds the stack pointer, its load/increment/decrement controls and an occupancy counter, and adds bounded-depth overflow/underflow detection, an optional halt-on-fault mode, and a one-deep shadow copy for interrupt context save/restore. It sits between the control unit and the scratch RAM address mux, in the same position as the current fixed 8-bit stack pointer.

## Interface
- WIDTH, 8: pointer width in bits; pointer arithmetic is modulo 2^WIDTH.
- DEPTH, 256: maximum number of entries that may be pushed; 1..2^WIDTH.
- RESET_VAL, 0: pointer value after reset and in the reset shadow copy.
- FAULT_HALT, 0: 0 = violating ops are dropped and a flag is set; 1 = a violation also freezes the unit in FAULT.
- CW: derived, clog2(DEPTH+1); width of the COUNT port.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; asynchronous, active-high.
- SP_LD  in  1  load A and start a new empty stack.
- SP_INCR  in  1  pop: pointer +1, count -1.
- SP_DECR  in  1  push: pointer -1, count +1.
- SP_SAVE  in  1  copy {DATA_OUT, COUNT} into the shadow register.
- SP_RESTORE  in  1  reload {DATA_OUT, COUNT} from the shadow register.
- CLR_FAULT  in  1  clear OVF, UNF and the FAULT state.
- A  in  WIDTH  load value.
- DATA_OUT  out  WIDTH  current stack pointer.
- COUNT  out  CW  current number of entries on the stack.
- EMPTY  out  1  COUNT == 0.
- FULL  out  1  COUNT == DEPTH.
- OVF  out  1  sticky: a push was attempted while FULL.
- UNF  out  1  sticky: a pop was attempted while EMPTY.
- FAULT  out  1  high while the FSM is in FAULT.

## Operation
- Reset values: DATA_OUT=RESET_VAL, COUNT=0, EMPTY=1, FULL=0, OVF=0, UNF=0, FAULT=0. The shadow register resets to {RESET_VAL, 0}. The FSM resets to RUN.
- FSM states:
  - RUN: normal operation.
  - FAULT: entered only when FAULT_HALT=1 and a violation occurs. Leaves to RUN on CLR_FAULT, SP_LD or SP_RESTORE.
- Priority per cycle: RESTORE > LD > INCR > DECR. Only the highest-priority pointer op takes effect. A lower op in the same cycle is ignored and is not checked for a violation.
- SP_RESTORE: {DATA_OUT, COUNT} <= shadow. Works in RUN and in FAULT.
- SP_LD: DATA_OUT <= A, COUNT <= 0. Works in RUN and in FAULT.
- SP_INCR:
  - If COUNT == 0: violation. UNF <= 1; pointer and count are unchanged.
  - Otherwise: DATA_OUT+1 (wraps 2^WIDTH-1 to 0) and COUNT-1.
- SP_DECR:
  - If COUNT == DEPTH: violation. OVF <= 1; pointer and count are unchanged.
  - Otherwise: DATA_OUT-1 (wraps 0 to 2^WIDTH-1) and COUNT+1.
- In FAULT, SP_INCR and SP_DECR are ignored, and no new flags are set.
- SP_SAVE captures the pre-edge {DATA_OUT, COUNT}. It is independent of the priority chain and may coincide with any op. SAVE together with RESTORE exchanges the values: the shadow gets the old live value, and the live value gets the old shadow.
- CLR_FAULT clears OVF, UNF and FAULT. If a violation occurs in the same cycle, the new violation's flag wins (set), and with FAULT_HALT=1 the FSM re-enters FAULT.
- EMPTY and FULL are decoded combinationally from the COUNT register. There is no combinational path from any input to any output.

## Timing
- Every op takes effect at the rising CLK edge where it is sampled. Results are visible on the outputs in the next cycle, giving single-cycle latency. Back-to-back ops every cycle are supported.
- RST asserted mid-operation forces all reset values immediately, without waiting for a clock edge. The first op after deassertion is honoured on the first rising edge that samples RST low.
- The sticky flags hold until CLR_FAULT or RST. The pointer and count are never modified by a violating op in either mode.

## Test plan
All scenarios use WIDTH=8, DEPTH=4, RESET_VAL=0x00 unless noted.
- Reset, then 4x SP_DECR -> DATA_OUT steps 0xFF, 0xFE, 0xFD, 0xFC; COUNT steps to 4; FULL=1. A 5th SP_DECR -> OVF=1, DATA_OUT stays 0xFC, COUNT stays 4.
- From reset, SP_INCR -> UNF=1, DATA_OUT=0x00, COUNT=0. Then CLR_FAULT -> UNF=0.
- FAULT_HALT=1: from FULL, SP_DECR -> FAULT=1. The next SP_INCR is ignored (COUNT stays 4). CLR_FAULT -> FAULT=0. Then SP_INCR -> DATA_OUT=0xFD, COUNT=3.
- SP_LD A=0x80, 2x SP_DECR (DATA_OUT=0x7E), SP_SAVE. Then SP_LD A=0x40 with SP_INCR and SP_DECR asserted in the same cycle -> DATA_OUT=0x40, COUNT=0, no flags. Then SP_RESTORE -> DATA_OUT=0x7E, COUNT=2.
- SP_LD, SP_INCR and SP_DECR asserted in one cycle with A=0x10 -> DATA_OUT=0x10 and COUNT=0. Next cycle SP_INCR and SP_DECR together -> INCR wins and is an underflow: UNF=1, OVF=0.
- Assert RST asynchronously between edges while COUNT=3 and OVF=1 -> all outputs read reset values before the next edge. The shadow register also returns to {0x00, 0}, so an immediate SP_RESTORE yields DATA_OUT=0x00, COUNT=0.
